// File: rtl/mul_pkg.sv
// Shared definitions for the Booth multiplier sequencer and its datapath.
// Command encodings driven on the datapath state bus, plus width defaults.
package mul_pkg;

    typedef enum logic [1:0] {
        START    = 2'b00,
        MULTIPLE = 2'b01,
        CLEAR    = 2'b10
    } dp_cmd_e;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_MAX   = 32;

endpackage

// File: rtl/mul_seq_if.sv
// Request/response and datapath command bundle for mul_seq.
// The slave modport is the sequencer's view; master is the parent/datapath side.
interface mul_seq_if
    import mul_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = 6
);
    logic                 start;
    logic                 start_ready;
    logic [WIDTH-1:0]     multiplier_in;
    logic [WIDTH-1:0]     multiplicand_in;
    logic [WIDTH-1:0]     multiplier;
    logic [WIDTH-1:0]     multiplicand;
    logic [1:0]           state;
    logic [CNT_W-1:0]     counter;
    logic                 op_done;
    logic [2*WIDTH-1:0]   result_in;
    logic                 res_valid;
    logic                 res_ready;
    logic [2*WIDTH-1:0]   res;
    logic                 busy;

    modport slave (
        input  start, multiplier_in, multiplicand_in, op_done, result_in, res_ready,
        output start_ready, multiplier, multiplicand, state, counter, res_valid, res, busy
    );

    modport master (
        output start, multiplier_in, multiplicand_in, op_done, result_in, res_ready,
        input  start_ready, multiplier, multiplicand, state, counter, res_valid, res, busy
    );
endinterface

// File: rtl/mul_seq.sv
// Sequencer for an external Booth datapath: accepts a request, steps the
// datapath, and holds the product until consumed. Optional abort: MUL_SEQ_ABORT_EN.
module mul_seq
    import mul_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = 6
) (
    input  logic clk,
    input  logic reset_n,
`ifdef MUL_SEQ_ABORT_EN
    input  logic abort,
`endif
    mul_seq_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_HOLD} fsm_e;

    localparam logic [CNT_W-1:0] C_MAX = CNT_W'(CNT_MAX);

    fsm_e               r_fsm, w_fsm_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_mplr, r_mcnd;
    logic [2*WIDTH-1:0] r_res;
    logic               r_res_valid;

    logic               w_accept, w_done, w_ack, w_abort;
    dp_cmd_e            w_cmd;
    logic               w_busy, w_start_ready;

    assign w_accept = bus.start && (r_fsm == S_IDLE);
    assign w_done   = bus.op_done && (r_fsm == S_RUN);
    assign w_ack    = bus.res_ready && (r_fsm == S_HOLD);
`ifdef MUL_SEQ_ABORT_EN
    assign w_abort  = abort && (r_fsm == S_LOAD || r_fsm == S_RUN);
`else
    assign w_abort  = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_fsm <= S_IDLE;
        else          r_fsm <= w_fsm_nxt;
    end

    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            S_IDLE: if (w_accept) w_fsm_nxt = S_LOAD;
            S_LOAD: w_fsm_nxt = S_RUN;
            S_RUN:  if (w_done) w_fsm_nxt = S_HOLD;
            S_HOLD: if (w_ack) w_fsm_nxt = S_IDLE;
            default: w_fsm_nxt = S_IDLE;
        endcase
        // Abort overrides a completion landing in the same cycle.
        if (w_abort) w_fsm_nxt = S_IDLE;
    end

    always_comb begin
        w_cmd         = START;
        w_busy        = 1'b1;
        w_start_ready = 1'b0;
        case (r_fsm)
            S_IDLE: begin
                w_busy        = 1'b0;
                w_start_ready = 1'b1;
            end
            S_RUN:   w_cmd = MULTIPLE;
            S_HOLD:  w_cmd = CLEAR;
            default: w_cmd = START;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt       <= '0;
            r_mplr      <= '0;
            r_mcnd      <= '0;
            r_res       <= '0;
            r_res_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_mplr <= bus.multiplier_in;
                r_mcnd <= bus.multiplicand_in;
                r_cnt  <= '0;
            end
            if (w_abort) begin
                r_cnt <= '0;
            end else if (r_fsm == S_RUN && r_cnt < C_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_done && !w_abort) begin
                r_res       <= bus.result_in;
                r_res_valid <= 1'b1;
            end
            if (w_ack) begin
                r_res_valid <= 1'b0;
                r_cnt       <= '0;
            end
        end
    end

    assign bus.start_ready  = w_start_ready;
    assign bus.busy         = w_busy;
    assign bus.state        = w_cmd;
    assign bus.counter      = r_cnt;
    assign bus.multiplier   = r_mplr;
    assign bus.multiplicand = r_mcnd;
    assign bus.res          = r_res;
    assign bus.res_valid    = r_res_valid;

endmodule

// File: tb/tb_mul_seq.sv
// Bench for mul_seq paired with a behavioural datapath that forms the signed
// product during LOAD and reports completion at the final Booth step.
module tb_mul_seq;
    import mul_pkg::*;

    localparam int W  = 32;
    localparam int CW = 6;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    mul_seq_if #(.WIDTH(W), .CNT_W(CW)) bus();
`ifdef MUL_SEQ_ABORT_EN
    logic abort = 1'b0;
`endif

    mul_seq #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
`ifdef MUL_SEQ_ABORT_EN
        .abort   (abort),
`endif
        .bus     (bus)
    );

    // Datapath model: product formed while commanded to load, done at step 32.
    logic signed [2*W-1:0] dp_prod;
    logic                  dp_force = 1'b0;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)                 dp_prod <= '0;
        else if (bus.state == 2'b00)  dp_prod <= $signed(bus.multiplier) * $signed(bus.multiplicand);
    end
    assign bus.op_done   = (bus.state == 2'b01 && bus.counter == CW'(32)) || dp_force;
    assign bus.result_in = dp_prod;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    function automatic logic [63:0] ref_mul(input int a, input int b);
        longint p;
        p = longint'(a) * longint'(b);
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // After this returns the DUT is in its LOAD cycle (cyc=1).
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.multiplier_in   = a;
        bus.multiplicand_in = b;
        bus.start           = 1'b1;
        tick();
        bus.start = 1'b0;
        cyc       = 1;
    endtask

    task automatic wait_valid();
        while (!bus.res_valid && cyc < 200) tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) tick();
        n_cmp++;
        if ({bus.state, bus.counter, bus.res_valid, bus.busy, bus.start_ready} !== {2'b00, 6'd0, 3'b001}) begin
            n_err++;
            $display("FAIL reset_ctrl got st=%b cnt=%0d rv=%b busy=%b rdy=%b want 00 0 0 0 1",
                     bus.state, bus.counter, bus.res_valid, bus.busy, bus.start_ready);
        end
        n_cmp++;
        if ({bus.res, bus.multiplier, bus.multiplicand} !== 128'd0) begin
            n_err++;
            $display("FAIL reset_data got res=%h a=%h b=%h want all zero", bus.res, bus.multiplier, bus.multiplicand);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_product();
        bus.res_ready = 1'b1;
        start_op(32'd3, 32'd5);
        n_cmp++;
        if ({bus.state, bus.counter, bus.busy, bus.start_ready} !== {2'b00, 6'd0, 2'b10}) begin
            n_err++;
            $display("FAIL load_cycle got st=%b cnt=%0d busy=%b rdy=%b want 00 0 1 0",
                     bus.state, bus.counter, bus.busy, bus.start_ready);
        end
        while (cyc < 34) tick();
        n_cmp++;
        if ({bus.state, bus.counter} !== {2'b01, 6'd32}) begin
            n_err++;
            $display("FAIL last_step got st=%b cnt=%0d want 01 32", bus.state, bus.counter);
        end
        wait_valid();
        n_cmp++;
        if (cyc !== 35) begin
            n_err++;
            $display("FAIL product_latency got %0d want 35", cyc);
        end
        n_cmp++;
        if (bus.res !== 64'h0000_0000_0000_000F) begin
            n_err++;
            $display("FAIL product_3x5 got %h want 000000000000000f", bus.res);
        end
        tick();
        n_cmp++;
        if ({bus.res_valid, bus.busy, bus.state, bus.counter, bus.res} !== {2'b00, 2'b00, 6'd0, 64'hF}) begin
            n_err++;
            $display("FAIL product_release got rv=%b busy=%b st=%b cnt=%0d res=%h want 0 0 00 0 f",
                     bus.res_valid, bus.busy, bus.state, bus.counter, bus.res);
        end
    endtask

    task automatic test_signed();
        bus.res_ready = 1'b1;
        start_op(-32'sd7, 32'sd6);
        wait_valid();
        n_cmp++;
        if (cyc !== 35 || bus.res !== 64'hFFFF_FFFF_FFFF_FFD6) begin
            n_err++;
            $display("FAIL signed_m7x6 got lat=%0d res=%h want 35 ffffffffffffffd6", cyc, bus.res);
        end
        tick();
    endtask

    task automatic test_random();
        int a, b;
        bus.res_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 0)      begin a = 32'h8000_0000; b = 32'h8000_0000; end
            else if (i == 1) begin a = -1;            b = 32'h7FFF_FFFF; end
            else if (i == 2) begin a = 0;             b = $urandom;      end
            else             begin a = $urandom;      b = $urandom;      end
            start_op(a, b);
            wait_valid();
            n_cmp++;
            if (cyc !== 35 || bus.res !== ref_mul(a, b)) begin
                n_err++;
                $display("FAIL random_%0d %h x %h got lat=%0d res=%h want 35 %h", i, a, b, cyc, bus.res, ref_mul(a, b));
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] held;
        bus.res_ready = 1'b0;
        start_op(32'd123, -32'sd45);
        wait_valid();
        held = bus.res;
        n_cmp++;
        if (cyc !== 35 || held !== ref_mul(123, -45)) begin
            n_err++;
            $display("FAIL bp_product got lat=%0d res=%h want 35 %h", cyc, held, ref_mul(123, -45));
        end
        bus.multiplier_in   = 32'd9;
        bus.multiplicand_in = 32'd9;
        bus.start           = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if ({bus.res_valid, bus.state} !== 3'b110 || bus.res !== held) begin
                n_err++;
                $display("FAIL bp_hold_%0d got rv=%b st=%b res=%h want 1 10 %h", i, bus.res_valid, bus.state, bus.res, held);
            end
        end
        bus.res_ready = 1'b1;
        tick();
        bus.start = 1'b0;
        n_cmp++;
        if ({bus.res_valid, bus.busy, bus.start_ready, bus.state} !== 5'b00100 || bus.res !== held ||
            bus.multiplier !== 32'd123) begin
            n_err++;
            $display("FAIL bp_release got rv=%b busy=%b rdy=%b st=%b res=%h a=%0d want 0 0 1 00 %h 123",
                     bus.res_valid, bus.busy, bus.start_ready, bus.state, bus.res, held, bus.multiplier);
        end
        tick();
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL bp_no_accept got busy=%b want 0", bus.busy);
        end
    endtask

    task automatic test_busy_reject();
        bus.res_ready = 1'b1;
        start_op(32'd3, 32'd5);
        while (cyc < 10) tick();
        bus.multiplier_in   = 32'd9;
        bus.multiplicand_in = 32'd9;
        bus.start           = 1'b1;
        tick();
        bus.start = 1'b0;
        n_cmp++;
        if (bus.multiplier !== 32'd3 || bus.multiplicand !== 32'd5 || bus.counter !== 6'd9) begin
            n_err++;
            $display("FAIL busy_operands got a=%0d b=%0d cnt=%0d want 3 5 9", bus.multiplier, bus.multiplicand, bus.counter);
        end
        wait_valid();
        n_cmp++;
        if (cyc !== 35 || bus.res !== 64'd15) begin
            n_err++;
            $display("FAIL busy_result got lat=%0d res=%h want 35 f", cyc, bus.res);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        logic seen;
        bus.res_ready = 1'b1;
        start_op(32'd77, 32'd88);
        while (cyc < 12) tick();
        n_cmp++;
        if (bus.counter !== 6'd10) begin
            n_err++;
            $display("FAIL rst_mid_cnt got %0d want 10", bus.counter);
        end
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.state, bus.counter, bus.res_valid, bus.busy, bus.start_ready} !== {2'b00, 6'd0, 3'b001} ||
            {bus.res, bus.multiplier, bus.multiplicand} !== 128'd0) begin
            n_err++;
            $display("FAIL rst_mid_outputs got st=%b cnt=%0d rv=%b busy=%b rdy=%b res=%h a=%h b=%h",
                     bus.state, bus.counter, bus.res_valid, bus.busy, bus.start_ready, bus.res, bus.multiplier, bus.multiplicand);
        end
        seen = 1'b0;
        repeat (3) begin tick(); seen |= bus.res_valid; end
        reset_n = 1'b1;
        repeat (40) begin tick(); seen |= bus.res_valid; end
        n_cmp++;
        if (seen !== 1'b0 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_discard got seen=%b busy=%b want 0 0", seen, bus.busy);
        end
        start_op(32'd2, 32'd2);
        wait_valid();
        n_cmp++;
        if (cyc !== 35 || bus.res !== 64'd4) begin
            n_err++;
            $display("FAIL rst_mid_resume got lat=%0d res=%h want 35 4", cyc, bus.res);
        end
        tick();
    endtask

    task automatic test_done_ignored();
        bus.res_ready = 1'b1;
        dp_force = 1'b1;
        repeat (2) tick();
        dp_force = 1'b0;
        n_cmp++;
        if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0 || bus.res !== 64'd4) begin
            n_err++;
            $display("FAIL done_idle got rv=%b busy=%b res=%h want 0 0 4", bus.res_valid, bus.busy, bus.res);
        end
        start_op(32'd6, 32'd7);
        dp_force = 1'b1;
        tick();
        dp_force = 1'b0;
        n_cmp++;
        if (bus.state !== 2'b01 || bus.res_valid !== 1'b0) begin
            n_err++;
            $display("FAIL done_load got st=%b rv=%b want 01 0", bus.state, bus.res_valid);
        end
        wait_valid();
        n_cmp++;
        if (cyc !== 35 || bus.res !== 64'd42) begin
            n_err++;
            $display("FAIL done_load_result got lat=%0d res=%h want 35 2a", cyc, bus.res);
        end
        tick();
    endtask

`ifdef MUL_SEQ_ABORT_EN
    task automatic test_abort();
        logic seen;
        bus.res_ready = 1'b1;
        start_op(32'd11, 32'd13);
        while (cyc < 9) tick();
        n_cmp++;
        if (bus.counter !== 6'd7) begin
            n_err++;
            $display("FAIL abort_cnt got %0d want 7", bus.counter);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_cmp++;
        if ({bus.state, bus.counter, bus.busy, bus.res_valid} !== 10'd0) begin
            n_err++;
            $display("FAIL abort_idle got st=%b cnt=%0d busy=%b rv=%b want 00 0 0 0",
                     bus.state, bus.counter, bus.busy, bus.res_valid);
        end
        seen = 1'b0;
        repeat (40) begin tick(); seen |= bus.res_valid; end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL abort_no_valid got seen=%b want 0", seen);
        end
    endtask
`endif

    initial begin
        bus.start           = 1'b0;
        bus.res_ready       = 1'b0;
        bus.multiplier_in   = '0;
        bus.multiplicand_in = '0;
        test_reset();
        test_product();
        test_signed();
        test_random();
        test_backpressure();
        test_busy_reject();
        test_reset_mid();
        test_done_ignored();
`ifdef MUL_SEQ_ABORT_EN
        test_abort();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
